// File: rtl/intercal_alu_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | intercal_alu_if : byte-wide write/select bus of the INTERCAL ALU      |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface intercal_alu_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface
`default_nettype wire

// File: rtl/intercal_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | intercal_alu : two byte-loaded 32-bit operands, INTERCAL ops, byte out |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module intercal_alu (
  input  logic               clk,
  input  logic               rst,
  intercal_alu_if.slave      bus
);

  localparam logic [2:0] OP_MINGLE = 3'b000;
  localparam logic [2:0] OP_SELECT = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_PASSA  = 3'b101;
  localparam logic [2:0] OP_PASSB  = 3'b110;

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] r;
  logic [31:0] mask;
  logic [31:0] a_m, b_m;
  logic [31:0] rot;
  logic [5:0]  idx;
  logic [2:0]  op;
  logic        wide;

  assign op   = bus.uio_in[6:4];
  assign wide = bus.uio_in[3];

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (bus.ena && bus.uio_in[7]) begin
      if (bus.uio_in[2]) b_d[{bus.uio_in[1:0], 3'b000} +: 8] = bus.ui_in;
      else               a_d[{bus.uio_in[1:0], 3'b000} +: 8] = bus.ui_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Rotation wraps within the selected width, so bit 0 lands on bit 15 in 16-bit mode.
  always_comb begin
    mask = wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    a_m  = a_q & mask;
    b_m  = b_q & mask;
    rot  = wide ? {a_q[0], a_q[31:1]} : {16'h0000, a_q[0], a_q[15:1]};
    r    = '0;
    idx  = '0;
    case (op)
      OP_MINGLE: begin
        for (int i = 0; i < 16; i++) begin
          r[2*i+1] = a_q[i];
          r[2*i]   = b_q[i];
        end
      end
      OP_SELECT: begin
        for (int i = 0; i < 32; i++) begin
          if (b_m[i]) begin
            r[idx[4:0]] = a_m[i];
            idx         = idx + 6'd1;
          end
        end
      end
      OP_AND:   r = a_m & rot;
      OP_OR:    r = a_m | rot;
      OP_XOR:   r = a_m ^ rot;
      OP_PASSA: r = a_m;
      OP_PASSB: r = b_m;
      default:  r = '0;
    endcase
  end

  assign bus.uo_out  = r[{bus.uio_in[1:0], 3'b000} +: 8];
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_intercal_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_intercal_alu : directed vectors plus per-cycle reference model     |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_intercal_alu;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  intercal_alu_if bus ();

  intercal_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  logic [31:0] ma, mb;

  function automatic logic [31:0] model_r(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic w);
    int          n;
    int          k;
    logic [31:0] m, aa, bb, rr, ror;
    n   = w ? 32 : 16;
    m   = w ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    aa  = a & m;
    bb  = b & m;
    rr  = 32'h0;
    k   = 0;
    ror = ((aa >> 1) | (aa << (n - 1))) & m;
    case (op)
      3'd0: for (int i = 0; i < 16; i++)
              rr = rr | (32'(a[i]) << (2*i + 1)) | (32'(b[i]) << (2*i));
      3'd1: for (int i = 0; i < n; i++)
              if (bb[i]) begin
                rr = rr | (32'(aa[i]) << k);
                k++;
              end
      3'd2:    rr = aa & ror;
      3'd3:    rr = aa | ror;
      3'd4:    rr = aa ^ ror;
      3'd5:    rr = aa;
      3'd6:    rr = bb;
      default: rr = 32'h0;
    endcase
    return rr;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= 32'h0;
      mb <= 32'h0;
    end else if (bus.ena && bus.uio_in[7]) begin
      if (bus.uio_in[2]) mb[8*bus.uio_in[1:0] +: 8] <= bus.ui_in;
      else               ma[8*bus.uio_in[1:0] +: 8] <= bus.ui_in;
    end
  end

  always @(negedge clk) begin
    logic [31:0] rm;
    rm = model_r(ma, mb, bus.uio_in[6:4], bus.uio_in[3]);
    chk("model_uo_out", {24'h0, bus.uo_out}, {24'h0, rm[8*bus.uio_in[1:0] +: 8]});
    chk("uio_out_zero", {24'h0, bus.uio_out}, 32'h0);
    chk("uio_oe_zero",  {24'h0, bus.uio_oe},  32'h0);
  end

  task automatic wr(input bit en, input logic [2:0] addr, input logic [7:0] d);
    @(posedge clk); #1;
    bus.ena    = en;
    bus.ui_in  = d;
    bus.uio_in = {1'b1, 3'b000, 1'b0, addr};
    @(posedge clk); #1;
    bus.uio_in[7] = 1'b0;
    bus.ena       = 1'b0;
  endtask

  task automatic load(input bit is_b, input logic [31:0] val);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] s;
      s = 2'(i);
      wr(1'b1, {is_b, s}, val[8*i +: 8]);
    end
  endtask

  task automatic view(input string name, input logic [2:0] op, input logic w,
                      input logic [31:0] exp);
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) begin
      logic [1:0] sel;
      sel        = 2'(s);
      bus.uio_in = {1'b0, op, w, 1'b0, sel};
      #1;
      chk(name, {24'h0, bus.uo_out}, {24'h0, exp[8*s +: 8]});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    bus.ena    = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    #3;
    for (int o = 0; o < 8; o++) begin
      bus.uio_in = {1'b0, 3'(o), 1'b1, 3'b000};
      #1;
      chk("reset_uo_out", {24'h0, bus.uo_out}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    view("post_reset_passa", 3'd5, 1'b1, 32'h0);

    // Mingle ignores width
    load(1'b0, 32'h0000_FFFF); load(1'b1, 32'h0);
    view("mingle_a", 3'd0, 1'b0, 32'hAAAA_AAAA);
    view("mingle_a_w32", 3'd0, 1'b1, 32'hAAAA_AAAA);
    load(1'b0, 32'h0); load(1'b1, 32'h0000_FFFF);
    view("mingle_b", 3'd0, 1'b1, 32'h5555_5555);

    load(1'b0, 32'h0000_1234); load(1'b1, 32'h0000_00FF);
    view("select16", 3'd1, 1'b0, 32'h0000_0034);
    load(1'b0, 32'hDEAD_BEEF); load(1'b1, 32'hFFFF_0000);
    view("select32", 3'd1, 1'b1, 32'h0000_DEAD);
    view("select16_b0", 3'd1, 1'b0, 32'h0);
    load(1'b1, 32'h0000_FFFF);
    view("select16_ones", 3'd1, 1'b0, 32'h0000_BEEF);
    view("passa16", 3'd5, 1'b0, 32'h0000_BEEF);
    view("passb32", 3'd6, 1'b1, 32'h0000_FFFF);
    view("zero_op", 3'd7, 1'b1, 32'h0);

    load(1'b0, 32'h0000_0003);
    view("and16", 3'd2, 1'b0, 32'h0000_0001);
    load(1'b0, 32'h0000_0001);
    view("or16", 3'd3, 1'b0, 32'h0000_8001);
    view("xor16", 3'd4, 1'b0, 32'h0000_8001);
    view("xor32", 3'd4, 1'b1, 32'h8000_0001);
    load(1'b0, 32'hFFFF_FFFF);
    view("and32", 3'd2, 1'b1, 32'hFFFF_FFFF);
    view("and16_upper_zero", 3'd2, 1'b0, 32'h0000_FFFF);

    // Write gating
    load(1'b1, 32'h0);
    wr(1'b0, 3'd5, 8'h11);
    view("gated_write", 3'd6, 1'b1, 32'h0);
    wr(1'b1, 3'd5, 8'h7F);
    view("addr5_write", 3'd6, 1'b1, 32'h0000_7F00);

    // Asynchronous reset mid-cycle discards loaded state
    load(1'b0, 32'hFFFF_FFFF); load(1'b1, 32'hFFFF_FFFF);
    @(posedge clk); #4;
    rst = 1'b1;
    for (int o = 0; o < 8; o++) begin
      bus.uio_in = {1'b0, 3'(o), 1'b1, 1'b0, 2'(o)};
      #1;
      chk("async_reset_uo", {24'h0, bus.uo_out}, 32'h0);
    end
    @(posedge clk); #1;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h55;
    bus.uio_in = 8'b1000_0000;
    @(posedge clk); #1;
    bus.ena    = 1'b0;
    bus.uio_in = 8'h00;
    rst        = 1'b0;
    view("strobe_in_reset", 3'd5, 1'b1, 32'h0);
    view("reset_b_cleared", 3'd6, 1'b1, 32'h0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/intercal_alu.md
INTERCAL_ALU -- requirements
Module: intercal_alu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset, clears all registers.
REQ-004 ena  input  1  write enable gate; 1 = block selected.
REQ-005 ui_in  input  8  data byte written into operand registers.
REQ-006 uio_in  input  8  control:
- [7] write strobe
- [6:4] opcode
- [3] width (0 = 16-bit, 1 = 32-bit)
- [2:0] byte address.
REQ-007 uo_out  output  8  selected result byte.
REQ-008 uio_out  output  8  SHALL be constant 0x00.
REQ-009 uio_oe  output  8  SHALL be constant 0x00; all uio pins are inputs.

Function
REQ-010 The block SHALL hold two 32-bit operand registers, A and B.
REQ-011 On a rising clk with ena=1 and uio_in[7]=1, ui_in SHALL be written into one operand byte:
- addr 0..3 -> A byte 0..3 (0 = LSB)
- addr 4..7 -> B byte 0..3.
Only that byte changes.
REQ-012 With ena=0 or uio_in[7]=0, A and B SHALL hold their values.
REQ-013 The 32-bit result R SHALL be combinational from A, B, opcode and width.
REQ-014 uo_out SHALL be combinational: uo_out = R byte uio_in[1:0], where 0 = bits 7:0 and 3 = bits 31:24.
REQ-015 A written operand byte SHALL be visible in uo_out in the cycle after the writing edge, i.e. one-clock latency.
REQ-016 In 16-bit width, operands are A[15:0] and B[15:0]. Every op other than mingle SHALL zero R[31:16].
REQ-017 Opcode 000, mingle ($): ignores width. For i = 0..15: R[2i+1] = A[i] and R[2i] = B[i].
REQ-018 Opcode 001, select (~):
- Bits of A at positions where B is 1 are packed into the LSBs of R.
- Packing preserves their relative order; remaining upper bits are 0.
- Width is 16 or 32 per uio_in[3].
REQ-019 Opcode 010, unary AND (&): R = A AND rotr(A,1), where rotr rotates within the selected width. Bit i = A[i] & A[i+1]; the MSB pairs with bit 0.
REQ-020 Opcode 011, unary OR (V): R = A OR rotr(A,1), with the same rotation rule.
REQ-021 Opcode 100, unary XOR (?): R = A XOR rotr(A,1), with the same rotation rule.
REQ-022 Remaining opcodes, each truncated to the selected width:
- 101: R = A
- 110: R = B
- 111: R = 0.
REQ-023 B SHALL NOT affect unary ops. A and B SHALL NOT affect opcode 111.
REQ-024 Select with B = 0 SHALL give R = 0. Select with B all-ones in the selected width SHALL give R = A in that width.
REQ-025 Changing opcode, width or byte select SHALL change uo_out in the same cycle, with no clock needed.
REQ-026 The block SHALL contain no other state.

Reset
REQ-027 Asserting rst SHALL clear A and B to 0 immediately, independent of clk.
REQ-028 While rst=1 and after release, uo_out SHALL be 0x00 for every opcode until a write occurs.
REQ-029 A write strobe during rst=1 SHALL be ignored.
REQ-030 Reset asserted mid-sequence SHALL discard all previously loaded bytes.

Verification
REQ-031 Mingle: load A=0x0000FFFF, B=0, opcode 000 -> R=0xAAAAAAAA (uo_out 0xAA for all byte selects). Load A=0, B=0xFFFF -> R=0x55555555.
REQ-032 Select: 16-bit, A=0x1234, B=0x00FF -> R=0x00000034. 32-bit, A=0xDEADBEEF, B=0xFFFF0000 -> R=0x0000DEAD.
REQ-033 Unary, 16-bit, with A=0x0003 / 0x0001 loaded before each check:
- AND, A=0x0003 -> R=0x00000001
- OR, A=0x0001 -> R=0x00008001
- XOR, A=0x0001 -> R=0x00008001.
REQ-034 Unary, 32-bit, with A=0x00000001 / 0xFFFFFFFF loaded before each check:
- XOR, A=0x00000001 -> R=0x80000001
- AND, A=0xFFFFFFFF -> R=0xFFFFFFFF.
REQ-035 Write gating: strobe with ena=0 -> no change. Strobe to addr 5 with 0x7F -> only B[15:8] = 0x7F, seen via opcode 110, byte select 1, on the next cycle.
REQ-036 Reset: load A=B=0xFFFFFFFF, assert rst asynchronously between clock edges -> uo_out = 0x00 at once for all opcodes; uio_oe = uio_out = 0x00 throughout.
